// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the detector labs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pattern_gen_pkg;

    // Default geometry: 8-bit pattern, 4-bit length so that 2**LEN_W > WIDTH.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;

    // FSM encodings. The values are also the LED display code on CurState.
    // ST_ILLEGAL is listed so that decoders can name it explicitly. It recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND    = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

endpackage

// File: rtl/serial_pattern_gen_piso.sv
// Parallel-in serial-out shift-left register. The serial output is the register MSB.
// Latency: load or shift takes effect on the next clk edge.
// Backpressure: none. load has priority over shift, and the register holds otherwise.
module piso_shift
    import serial_pattern_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // Next contents: parallel load wins, otherwise shift left and fill with zero.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = par_in;
        end else if (shift) begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_out = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial MSB-first pattern transmitter with Start/Busy/Done handshake, repeat and abort.
// Latency: the first bit appears on w_out in the cycle after the Start edge. All outputs are registered.
// Backpressure: none. Load and Start are honoured only in IDLE, and Abort only in SEND.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] Data,
    input  logic [LEN_W-1:0] Len,
    input  logic             Load,
    input  logic             Start,
    input  logic             Repeat,
    input  logic             Abort,
    output logic             w_out,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       CurState
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;      // retained pattern, untouched during SEND
    logic [LEN_W-1:0] len_q, len_d;      // retained (clamped) length
    logic [LEN_W-1:0] cnt_q, cnt_d;      // bits still to follow the one on w_out
    logic             w_out_q, w_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Values the IDLE state would act on. A same-edge Load overrides the stored pattern and length.
    logic [LEN_W-1:0] len_clamp;
    logic [WIDTH-1:0] eff_pat;
    logic [LEN_W-1:0] eff_len;

    // Working-copy shifter controls. The shifter holds the bits after the one currently on w_out.
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_par;
    logic             sh_msb;

    // Clamp oversized lengths and select the pattern and length a Start would use.
    always_comb begin
        len_clamp = (Len > WIDTH_L) ? WIDTH_L : Len;
        eff_pat   = Load ? Data      : pat_q;
        eff_len   = Load ? len_clamp : len_q;
    end

    // Next-state logic, kept apart from the datapath.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = (eff_len == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if ((cnt_q == '0) && !Repeat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: pattern capture, counter, shifter control and next serial bit.
    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        w_out_d  = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_par   = {pat_q[WIDTH-2:0], 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    pat_d = Data;
                    len_d = len_clamp;
                end
                if (Start && (eff_len != '0)) begin
                    w_out_d = eff_pat[WIDTH-1];
                    cnt_d   = eff_len - ONE_L;
                    sh_load = 1'b1;
                    sh_par  = {eff_pat[WIDTH-2:0], 1'b0};
                end
            end
            ST_SEND: begin
                if (!Abort) begin
                    if (cnt_q != '0) begin
                        w_out_d  = sh_msb;
                        sh_shift = 1'b1;
                        cnt_d    = cnt_q - ONE_L;
                    end else if (Repeat) begin
                        // Back-to-back repetition: the MSB follows the last bit with no gap.
                        w_out_d = pat_q[WIDTH-1];
                        cnt_d   = len_q - ONE_L;
                        sh_load = 1'b1;
                    end
                end
            end
            default: begin
                w_out_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_SEND);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            w_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            w_out_q <= w_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (Clock),
        .rst_n   (Resetn),
        .load    (sh_load),
        .shift   (sh_shift),
        .par_in  (sh_par),
        .ser_out (sh_msb)
    );

    assign w_out    = w_out_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign CurState = state_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Testbench for serial_pattern_gen: directed scenarios followed by random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_pattern_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             Clock  = 1'b0;
    logic             Resetn = 1'b1;
    logic [WIDTH-1:0] Data   = '0;
    logic [LEN_W-1:0] Len    = '0;
    logic             Load   = 1'b0;
    logic             Start  = 1'b0;
    logic             Repeat = 1'b0;
    logic             Abort  = 1'b0;
    logic             w_out;
    logic             Busy;
    logic             Done;
    logic [1:0]       CurState;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 sending, 2 done; m_k is the index (from the MSB) of the bit on the wire.
    int               m_state = 0;
    int               m_k     = 0;
    int               m_len   = 0;
    logic [WIDTH-1:0] m_pat   = '0;

    // Sliding window of the last four transmitted bits, standing in for a sequence detector.
    logic [3:0]       win = '0;

    serial_pattern_gen #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Data     (Data),
        .Len      (Len),
        .Load     (Load),
        .Start    (Start),
        .Repeat   (Repeat),
        .Abort    (Abort),
        .w_out    (w_out),
        .Busy     (Busy),
        .Done     (Done),
        .CurState (CurState)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_k     = 0;
        m_len   = 0;
        m_pat   = '0;
    endtask

    // Advance the model by one clock edge using the input values present at that edge.
    task automatic model_edge();
        int el;
        case (m_state)
            0: begin
                el = Load ? ((int'(Len) > WIDTH) ? WIDTH : int'(Len)) : m_len;
                if (Load) begin
                    m_pat = Data;
                    m_len = el;
                end
                if (Start) begin
                    m_state = (el == 0) ? 2 : 1;
                    m_k     = 0;
                end
            end
            1: begin
                if (Abort) begin
                    m_state = 0;
                end else if (m_k == m_len - 1) begin
                    if (Repeat) m_k = 0;
                    else        m_state = 2;
                end else begin
                    m_k++;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    // One clock: update the model, wait for the edge, and compare all outputs just after it.
    task automatic cycle();
        logic exp_w;
        model_edge();
        @(posedge Clock);
        #1;
        exp_w = (m_state == 1) ? m_pat[WIDTH-1-m_k] : 1'b0;
        chk("state", CurState, m_state);
        chk("busy", Busy, (m_state == 1));
        chk("done", Done, (m_state == 2));
        chk("w_out", w_out, exp_w);
        if (Busy) win = {win[2:0], w_out};
    endtask

    // Assert reset between clock edges and check that the outputs clear without a clock edge.
    task automatic async_reset();
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_w", w_out, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_state", CurState, 0);
        chk("arst_done", Done, 0);
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic rp, input logic ab,
                         input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        Load   = ld;
        Start  = st;
        Repeat = rp;
        Abort  = ab;
        Data   = d;
        Len    = l;
    endtask

    task automatic idle_inputs();
        Load  = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [3:0] exp_seq;

        // Power-on reset.
        #1 Resetn = 1'b0;
        #2;
        chk("rst_w", w_out, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_state", CurState, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Basic 4-bit send of 1101.
        exp_seq = 4'b1101;
        drive(1, 0, 0, 0, 8'b1101_0000, 4'd4);
        cycle();
        drive(0, 1, 0, 0, 8'h00, 4'd0);
        cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            chk("t1_bit", w_out, exp_seq[3-i]);
            chk("t1_busy", Busy, 1);
            if (i < 3) cycle();
        end
        cycle();
        chk("t1_done", Done, 1);
        cycle();
        chk("t1_idle", CurState, 0);

        // Detector loopback: 1111, then 1101.
        win = '0;
        drive(1, 1, 0, 0, 8'b1111_0000, 4'd4);
        cycle();
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();
        chk("det_1111", win, 4'b1111);
        drive(1, 1, 0, 0, 8'b1101_0000, 4'd4);
        cycle();
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();
        chk("det_1101", win, 4'b1101);

        // Repeat mode: continuous 1010 stream, then stop on the final bit of a repetition.
        drive(1, 1, 1, 0, 8'b1010_0000, 4'd4);
        cycle();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            chk("rep_bit", w_out, (i % 2 == 0));
            cycle();
        end
        for (int g = 0; g < 8 && m_k != 3; g++) cycle();
        Repeat = 1'b0;
        cycle();
        chk("rep_stop_done", Done, 1);
        cycle();

        // Zero length goes straight to DONE.
        drive(1, 1, 0, 0, 8'hFF, 4'd0);
        cycle();
        idle_inputs();
        chk("len0_state", CurState, 2'b10);
        cycle();
        chk("len0_idle", CurState, 0);

        // An oversized length is clamped to WIDTH.
        drive(1, 1, 0, 0, 8'hA5, 4'd12);
        cycle();
        idle_inputs();
        cnt = Busy ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (Busy) cnt++;
        end
        chk("clamp_bits", cnt, 8);

        // Abort at the third bit, then restart from the retained pattern.
        drive(1, 1, 0, 0, 8'b1011_0110, 4'd8);
        cycle();
        idle_inputs();
        cycle();
        cycle();
        Abort = 1'b1;
        cycle();
        chk("abort_state", CurState, 0);
        chk("abort_nodone", Done, 0);
        Abort = 1'b0;
        Start = 1'b1;
        cycle();
        Start = 1'b0;
        chk("restart_msb", w_out, 1);
        for (int i = 0; i < 10; i++) cycle();

        // Asynchronous reset in the middle of a send.
        drive(1, 1, 0, 0, 8'h96, 4'd8);
        cycle();
        idle_inputs();
        cycle();
        async_reset();

        // Load during SEND must not disturb the retained pattern.
        drive(1, 1, 0, 0, 8'h3C, 4'd8);
        cycle();
        drive(1, 0, 0, 0, 8'hFF, 4'd2);
        cycle();
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle();
        Start = 1'b1;
        cycle();
        Start = 1'b0;
        chk("retain_bit0", w_out, 0);
        cycle();
        cycle();
        chk("retain_bit2", w_out, 1);
        for (int i = 0; i < 10; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            Load   = ($urandom % 5) == 0;
            Start  = ($urandom % 3) == 0;
            Repeat = ($urandom % 3) == 0;
            Abort  = ($urandom % 20) == 0;
            Data   = WIDTH'($urandom);
            Len    = LEN_W'($urandom_range(0, 15));
            if (($urandom % 400) == 0) async_reset();
            else                       cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
